// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - control, byte stream and store write port bundle of the instruction memory loader
interface instr_mem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, num_words, in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );

  modport slave (
    input  start, num_words, in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte stream to big-endian word writer for the instruction store; LOADER_CHECKSUM_EN adds a trailing XOR checksum check
module instr_mem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic               clk,
  input logic               reset,
  instr_mem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic              error_q;
  logic              in_ready_w;
  logic              accept;
  logic              last_byte;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       csum_q;
  logic [31:0]       chk_q;
`endif

  assign accept    = bus.in_valid && in_ready_w;
  assign last_byte = (byte_cnt_q == 2'd3);
  assign last_word = ((word_cnt_q + ONE_W) == count_q);

  // Byte acceptance is only open while collecting word bytes or checksum bytes
  always_comb begin
    in_ready_w = 1'b0;
    if (state_q == S_RECV) in_ready_w = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    if (state_q == S_CHECK) in_ready_w = 1'b1;
`endif
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word_q;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.error     = error_q;

  // State register; reset drops mem_we without waiting for a clock edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          if (bus.num_words == '0)          state_d = S_DONE;
          else if (bus.num_words > DEPTH_W) state_d = S_DONE;
          else                              state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (accept && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        state_d = last_word ? S_CHECK : S_RECV;
`else
        state_d = last_word ? S_DONE : S_RECV;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept && last_byte) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Word assembly, counters, held write address and status flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
      chk_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            count_q    <= bus.num_words;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            // Oversized requests end immediately as errors with no writes
            error_q    <= (bus.num_words > DEPTH_W);
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        S_RECV: begin
          if (accept) begin
            word_q     <= {word_q[23:0], bus.in_byte};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            // Address is captured here so it stays put through WRITE and DONE
            if (last_byte) addr_q <= word_cnt_q[ADDR_W-1:0];
          end
        end
        S_WRITE: begin
          word_cnt_q <= word_cnt_q + ONE_W;
`ifdef LOADER_CHECKSUM_EN
          csum_q     <= csum_q ^ word_q;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            // Separate register keeps mem_wdata showing the last written word
            chk_q      <= {chk_q[23:0], bus.in_byte};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (last_byte) error_q <= ({chk_q[23:0], bus.in_byte} != csum_q);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader (vector table, hand sequences, random loads vs word-list model)
module tb_instr_mem_loader;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;

  instr_mem_loader_if #(.ADDR_W(5)) bif ();

  instr_mem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] words_g [0:63];
  int          cap_addr [$];
  logic [31:0] cap_data [$];
  int          cap_cyc  [$];
  int          rw_viol;

  // Record every store write and any cycle where a byte could be accepted during a write
  always @(negedge clk) begin
    if (bif.mem_we) begin
      cap_addr.push_back(32'(bif.mem_addr));
      cap_data.push_back(bif.mem_wdata);
      cap_cyc.push_back(cyc);
    end
    if (bif.mem_we && bif.in_ready) rw_viol <= rw_viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xor_words(input int n);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < n && i < 64; i++) x ^= words_g[i];
    return x;
  endfunction

  function automatic logic [7:0] stream_byte(input int j, input int nw, input logic [31:0] chk);
    logic [31:0] w;
    if (j >= 4 * nw) w = chk;
    else             w = words_g[j / 4];
    return w[31 - 8 * (j % 4) -: 8];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start(input int nw);
    @(posedge clk); #1;
    bif.start     = 1'b1;
    bif.num_words = 6'(nw);
    @(posedge clk); #1;
    bif.start     = 1'b0;
    @(negedge clk);
  endtask

  // Present one byte at a negedge and hold it until the loader takes it
  task automatic feed(input logic [7:0] b);
    logic acc;
    int   k;
    acc = 1'b0;
    k   = 0;
    bif.in_valid = 1'b1;
    bif.in_byte  = b;
    while (!acc && k < 50) begin
      #1 acc = bif.in_ready;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    bif.in_valid = 1'b0;
    if (!acc) check("feed_timeout", 32'd0, 32'd1);
  endtask

  // mode 0: in_valid held high, 1: toggled each cycle, 2: random
  task automatic run_load(input int nw, input int mode, input logic [31:0] chk,
                          input int exp_n, input logic exp_err);
    int          total, idx, budget, base, viol0, k, n;
    logic        tog, acc;
    logic [31:0] x;
    base  = cap_addr.size();
    viol0 = rw_viol;
    total = 0;
    if (nw >= 1 && nw <= 32) total = 4 * nw;
`ifdef LOADER_CHECKSUM_EN
    if (total > 0) total += 4;
`endif
    do_start(nw);
    if (nw == 0 || nw > 32) check("early_done", 32'(bif.done), 32'd1);
    else                    check("early_ready", 32'(bif.in_ready), 32'd1);
    idx = 0; budget = 0; tog = 1'b1;
    while (idx < total && budget < 40 * total + 20) begin
      case (mode)
        0:       bif.in_valid = 1'b1;
        1:       bif.in_valid = tog;
        default: bif.in_valid = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      bif.in_byte = stream_byte(idx, nw, chk);
      #1 acc = bif.in_valid && bif.in_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      budget++;
    end
    bif.in_valid = 1'b0;
    if (idx < total) check("byte_budget", 32'(idx), 32'(total));
    k = 0;
    while (!bif.done && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("done", 32'(bif.done), 32'd1);
    check("error", 32'(bif.error), 32'(exp_err));
    n = cap_addr.size() - base;
    check("nwrites", 32'(n), 32'(exp_n));
    x = '0;
    for (int i = 0; i < n && i < exp_n; i++) begin
      check("waddr", 32'(cap_addr[base + i]), 32'(i));
      check("wdata", cap_data[base + i], words_g[i]);
    end
    if (mode == 0 && n >= 2 && exp_n >= 2)
      check("write_spacing", 32'(cap_cyc[base + 1] - cap_cyc[base]), 32'd5);
    check("ready_in_write", 32'(rw_viol - viol0), 32'd0);
  endtask

  typedef struct {
    int          nw;
    int          mode;
    logic [31:0] w0;
    logic [31:0] w1;
    int          exp_n;
    logic        exp_err;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int          nw, n, mode;
    logic        err;
    logic [31:0] chk;
    checks = 0; failures = 0; cyc = 0; rw_viol = 0;
    bif.start = 1'b0; bif.num_words = '0; bif.in_valid = 1'b0; bif.in_byte = '0;

    tbl[0] = '{2,  0, 32'h8C010004, 32'h20020005, 2,  1'b0};
    tbl[1] = '{2,  1, 32'h8C010004, 32'h20020005, 2,  1'b0};
    tbl[2] = '{0,  0, 32'h0,        32'h0,        0,  1'b0};
    tbl[3] = '{33, 0, 32'h0,        32'h0,        0,  1'b1};
    tbl[4] = '{32, 0, 32'h0,        32'h1,        32, 1'b0};
    tbl[5] = '{3,  2, 32'hCAFEF00D, 32'h01234567, 3,  1'b0};

    do_reset();
    check("rst_in_ready",  32'(bif.in_ready), 32'd0);
    check("rst_mem_we",    32'(bif.mem_we),   32'd0);
    check("rst_mem_addr",  32'(bif.mem_addr), 32'd0);
    check("rst_mem_wdata", bif.mem_wdata,     32'd0);
    check("rst_busy",      32'(bif.busy),     32'd0);
    check("rst_done",      32'(bif.done),     32'd0);
    check("rst_error",     32'(bif.error),    32'd0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 2; i < 64; i++) words_g[i] = 32'(i);
      words_g[0] = tbl[t].w0;
      words_g[1] = tbl[t].w1;
      run_load(tbl[t].nw, tbl[t].mode, xor_words(tbl[t].nw), tbl[t].exp_n, tbl[t].exp_err);
    end

    // Reset during a WRITE cycle must kill the strobe without a clock edge
    words_g[0] = 32'h11223344;
    do_start(2);
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
    check("we_before_rst", 32'(bif.mem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_we",   32'(bif.mem_we), 32'd0);
    check("rst_async_busy", 32'(bif.busy),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset after two bytes of the second word, then a clean reload
    do_start(2);
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
    feed(8'h55); feed(8'h66);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy",  32'(bif.busy),     32'd0);
    check("rst_mid_ready", 32'(bif.in_ready), 32'd0);
    check("rst_mid_we",    32'(bif.mem_we),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    words_g[0] = 32'hDEADBEEF;
    run_load(1, 0, 32'hDEADBEEF, 1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    words_g[0] = 32'h0000000F;
    words_g[1] = 32'h000000F0;
    run_load(2, 0, 32'h000000FF, 2, 1'b0);
    run_load(2, 1, 32'h000000FE, 2, 1'b1);
`endif

    // Random loads against the word-list model
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 7) == 0) nw = $urandom_range(30, 34);
      else                           nw = $urandom_range(0, 5);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 64; i++) words_g[i] = $urandom;
      n   = (nw >= 1 && nw <= 32) ? nw : 0;
      chk = xor_words(n);
      err = (nw > 32);
`ifdef LOADER_CHECKSUM_EN
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        chk = chk ^ (32'd1 << $urandom_range(0, 31));
        err = 1'b1;
      end
`endif
      run_load(nw, mode, chk, n, err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
